// File: rtl/snapshot_sequencer.sv
// Snapshot RAM sequencer: captures one collision pass of moment samples, then freezes it for host reads.
// Optional pass-index tagging of the frozen frame is enabled by defining SNAP_FRAME_TAG_EN.
//
//   state   | meaning
//   IDLE    | no snapshot requested, RAM untouched
//   ARM     | waiting for a settled quiet period, then the next pass start
//   CAPTURE | collider samples written to RAM until the pass ends
//   HOLD    | frame frozen, host reads served
module snapshot_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int SETTLE = 4,
  parameter int CMD_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_collision_state,
  input  logic              collider_ready,
  input  logic [CMD_W-1:0]  host_cmd,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic              buf_re,
  output logic [ADDR_W-1:0] buf_raddr,
  output logic              snap_valid,
  output logic [ADDR_W:0]   snap_count,
  output logic              busy,
  output logic              overflow,
  output logic              addr_err,
  output logic [15:0]       snap_frame
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_HOLD} state_t;

  localparam int              SET_W    = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  logic              host_active;
  logic              snap_req;
  logic [ADDR_W-1:0] host_addr;
  logic              unused_cmd_bits;

  assign host_active     = host_cmd[CMD_W-1];
  assign snap_req        = host_cmd[CMD_W-2];
  assign host_addr       = host_cmd[ADDR_W-1:0];
  assign unused_cmd_bits = ^host_cmd[CMD_W-3:ADDR_W];

  state_t            state_q, state_d;
  logic              coll_prev_q;
  logic              coll_rise;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   snap_count_q, snap_count_d;
  logic              snap_valid_q, snap_valid_d;
  logic              overflow_q, overflow_d;
  logic              addr_err_q, addr_err_d;
  logic              buf_re_q, buf_re_d;
  logic [ADDR_W-1:0] buf_raddr_q, buf_raddr_d;
  logic              buf_we_c;
  logic              start_capture;

  assign coll_rise = in_collision_state & ~coll_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      coll_prev_q  <= 1'b0;
      settle_q     <= '0;
      ptr_q        <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      buf_re_q     <= 1'b0;
      buf_raddr_q  <= '0;
    end else begin
      state_q      <= state_d;
      coll_prev_q  <= in_collision_state;
      settle_q     <= settle_d;
      ptr_q        <= ptr_d;
      snap_count_q <= snap_count_d;
      snap_valid_q <= snap_valid_d;
      overflow_q   <= overflow_d;
      addr_err_q   <= addr_err_d;
      buf_re_q     <= buf_re_d;
      buf_raddr_q  <= buf_raddr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_d      = '0;
    ptr_d         = ptr_q;
    snap_count_d  = snap_count_q;
    snap_valid_d  = snap_valid_q;
    overflow_d    = overflow_q;
    addr_err_d    = addr_err_q;
    buf_re_d      = 1'b0;
    buf_raddr_d   = buf_raddr_q;
    buf_we_c      = 1'b0;
    start_capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snap_req && !host_active) state_d = S_ARM;
      end
      S_ARM: begin
        if (!in_collision_state) begin
          settle_d = (settle_q == SETTLE_C) ? settle_q : settle_q + 1'b1;
        end
        // a pass that starts before the quiet period has settled is skipped entirely
        if (!snap_req) begin
          state_d = S_IDLE;
        end else if (coll_rise && settle_q == SETTLE_C) begin
          state_d       = S_CAPTURE;
          ptr_d         = '0;
          overflow_d    = 1'b0;
          start_capture = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (in_collision_state) begin
          if (collider_ready) begin
            if (ptr_q < DEPTH_C) begin
              buf_we_c = 1'b1;
              ptr_d    = ptr_q + 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else begin
          state_d      = S_HOLD;
          snap_count_d = ptr_q;
          snap_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (host_active) begin
          buf_re_d    = 1'b1;
          buf_raddr_d = host_addr;
          if ({1'b0, host_addr} >= snap_count_q) addr_err_d = 1'b1;
        end else if (!snap_req) begin
          state_d      = S_IDLE;
          snap_valid_d = 1'b0;
          addr_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign buf_we     = buf_we_c;
  assign buf_waddr  = buf_we_c ? ptr_q[ADDR_W-1:0] : '0;
  assign buf_re     = buf_re_q;
  assign buf_raddr  = buf_raddr_q;
  assign snap_valid = snap_valid_q;
  assign snap_count = snap_count_q;
  assign busy       = (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;

`ifdef SNAP_FRAME_TAG_EN
  logic        coll_fall;
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] snap_frame_q, snap_frame_d;

  assign coll_fall = coll_prev_q & ~in_collision_state;

  always_comb begin
    pass_cnt_d   = coll_fall ? pass_cnt_q + 16'd1 : pass_cnt_q;
    snap_frame_d = start_capture ? pass_cnt_q : snap_frame_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q   <= '0;
      snap_frame_q <= '0;
    end else begin
      pass_cnt_q   <= pass_cnt_d;
      snap_frame_q <= snap_frame_d;
    end
  end

  assign snap_frame = snap_frame_q;
`else
  logic unused_start_capture;
  assign unused_start_capture = start_capture;
  assign snap_frame = 16'h0000;
`endif

endmodule

// File: tb/tb_snapshot_sequencer.sv
// Directed bench for snapshot_sequencer: a full-depth instance and a DEPTH=4 instance share stimulus.
// Expected frame tag follows SNAP_FRAME_TAG_EN.
module tb_snapshot_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_coll;
  logic        ready;
  logic [31:0] host_cmd;

  logic        we, re, sv, busy, ovf, aerr;
  logic [9:0]  waddr, raddr;
  logic [10:0] cnt;
  logic [15:0] frame;

  logic        we4, re4, sv4, busy4, ovf4, aerr4;
  logic [9:0]  waddr4, raddr4;
  logic [10:0] cnt4;
  logic [15:0] frame4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snapshot_sequencer u_dut (
    .clk(clk), .rst(rst), .in_collision_state(in_coll), .collider_ready(ready),
    .host_cmd(host_cmd), .buf_we(we), .buf_waddr(waddr), .buf_re(re), .buf_raddr(raddr),
    .snap_valid(sv), .snap_count(cnt), .busy(busy), .overflow(ovf), .addr_err(aerr),
    .snap_frame(frame)
  );

  snapshot_sequencer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_collision_state(in_coll), .collider_ready(ready),
    .host_cmd(host_cmd), .buf_we(we4), .buf_waddr(waddr4), .buf_re(re4), .buf_raddr(raddr4),
    .snap_valid(sv4), .snap_count(cnt4), .busy(busy4), .overflow(ovf4), .addr_err(aerr4),
    .snap_frame(frame4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input bit ha, input bit sr, input int addr);
    host_cmd = {ha, sr, 20'd0, 10'(addr)};
  endtask

  task automatic arm();
    set_cmd(1'b0, 1'b1, 0);
    tick();
    repeat (5) tick();
    chk("busy_arm", busy, 1);
  endtask

  // one pass of n samples; chk4 also verifies the DEPTH=4 instance's writes
  task automatic run_pass(input int n, input bit chk4);
    in_coll = 1'b1;
    #1;
    chk("we_rise", we, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      ready = 1'b1;
      #1;
      chk("we", we, 1);
      chk("waddr", waddr, i);
      if (chk4) begin
        chk("we4", we4, (i < 4) ? 1 : 0);
        if (i < 4) chk("waddr4", waddr4, i);
      end
      tick();
    end
    ready   = 1'b0;
    in_coll = 1'b0;
    #1;
    chk("we_fall", we, 0);
    tick();
  endtask

  task automatic release_hold();
    set_cmd(1'b0, 1'b0, 0);
    tick();
    chk("sv_released", sv, 0);
    chk("aerr_released", aerr, 0);
  endtask

  initial begin
    rst = 1'b1; in_coll = 1'b0; ready = 1'b0; host_cmd = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_sv", sv, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_re", re, 0);
    chk("rst_frame", frame, 0);

    // basic 8-sample capture; DEPTH=4 instance overflows
    arm();
    run_pass(8, 1'b1);
    chk("cnt8", cnt, 8);
    chk("sv8", sv, 1);
    chk("busy_hold", busy, 0);
    chk("ovf_none", ovf, 0);
    chk("cnt4_sat", cnt4, 4);
    chk("ovf4", ovf4, 1);

    // host reads in HOLD
    set_cmd(1'b1, 1'b1, 3);
    #1;
    chk("re_latency", re, 0);
    tick();
    chk("re3", re, 1);
    chk("raddr3", raddr, 3);
    chk("aerr_ok", aerr, 0);
    set_cmd(1'b1, 1'b1, 8);
    tick();
    chk("raddr8", raddr, 8);
    chk("aerr_at_count", aerr, 1);
    set_cmd(1'b1, 1'b0, 9);
    tick();
    chk("re9", re, 1);
    chk("hold_while_active", sv, 1);
    chk("aerr_sticky", aerr, 1);
    release_hold();
    chk("re_idle", re, 0);

    // host read outside HOLD is ignored
    set_cmd(1'b1, 1'b0, 5);
    tick();
    tick();
    chk("re_outside", re, 0);
    chk("aerr_outside", aerr, 0);
    set_cmd(1'b0, 1'b0, 0);
    tick();

    // pass starting after only 2 quiet cycles is skipped
    set_cmd(1'b0, 1'b1, 0);
    tick();
    tick();
    tick();
    in_coll = 1'b1;
    ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("we_unsettled", we, 0);
      tick();
    end
    in_coll = 1'b0;
    ready   = 1'b0;
    tick();
    chk("busy_still_arm", busy, 1);
    repeat (5) tick();
    run_pass(3, 1'b0);
    chk("cnt3", cnt, 3);
    release_hold();

    // 6 samples: DEPTH=4 instance writes 0..3 only
    arm();
    in_coll = 1'b1;
    tick();
    chk("ovf4_cleared", ovf4, 0);
    for (int i = 0; i < 6; i++) begin
      ready = 1'b1;
      #1;
      chk("we6", we, 1);
      chk("we4_6", we4, (i < 4) ? 1 : 0);
      if (i < 4) chk("waddr4_6", waddr4, i);
      tick();
    end
    ready   = 1'b1;
    in_coll = 1'b0;
    #1;
    chk("we_on_fall_sample", we, 0);
    tick();
    ready = 1'b0;
    chk("cnt6", cnt, 6);
    chk("cnt4_6", cnt4, 4);
    chk("ovf4_6", ovf4, 1);
    chk("ovf_6", ovf, 0);
    release_hold();

    // async reset mid-capture after 5 writes
    arm();
    in_coll = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ready = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf4", ovf4, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_sv", sv, 0);
    tick();
    rst = 1'b0; in_coll = 1'b0; ready = 1'b0;
    tick();
    arm();
    run_pass(2, 1'b0);
    chk("cnt_after_rst", cnt, 2);
    release_hold();

    // frame tag: three passes, capture on the fourth
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int p = 0; p < 3; p++) begin
      in_coll = 1'b1;
      tick();
      tick();
      in_coll = 1'b0;
      tick();
      tick();
    end
    arm();
    run_pass(1, 1'b0);
`ifdef SNAP_FRAME_TAG_EN
    chk("frame", frame, 3);
`else
    chk("frame", frame, 0);
`endif
    release_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snapshot_sequencer.md
Name: snapshot_sequencer

Overview:
- Controller for the moment-readout buffer: sequences capture of one complete collision pass (u_x, u_y, rho, u²) into the shared snapshot RAM, then freezes it for host reads.
- Arbitrates the RAM between collider writes and GPIO host reads so the host never sees a half-written frame.
- Sits between the collider/state control and the snapshot RAM; driven by the GPIO command word.

Parameters:
ADDR_W, 10, snapshot RAM address width (matches `ADDRESS_WIDTH)
DEPTH, 1024, number of RAM entries; must be ≤ 2^ADDR_W
SETTLE, 4, consecutive cycles in_collision_state must be low before a capture may arm
CMD_W, 32, GPIO command word width (matches `DATA_WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_collision_state  in  1  high while the collider pass runs
collider_ready  in  1  one valid moment sample this cycle
host_cmd  in  CMD_W  [CMD_W-1]=host_active, [CMD_W-2]=snap_req, [ADDR_W-1:0]=read address
buf_we  out  1  RAM write enable
buf_waddr  out  ADDR_W  RAM write address
buf_re  out  1  RAM read enable
buf_raddr  out  ADDR_W  RAM read address
snap_valid  out  1  frozen frame available to host
snap_count  out  ADDR_W+1  entries written in the frozen frame
busy  out  1  state is ARM or CAPTURE
overflow  out  1  sticky: sample arrived with DEPTH entries already written
addr_err  out  1  sticky: host read at address ≥ snap_count
snap_frame  out  16  collision-pass index of the frozen frame (see Optional Feature)

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal counters 0.
- States: IDLE, ARM, CAPTURE, HOLD.
- IDLE: buf_we=0, buf_re=0. snap_req=1 and host_active=0 → ARM.
- ARM: a settle counter counts cycles with in_collision_state=0 and saturates at SETTLE; it clears whenever in_collision_state=1.
  - Rising edge of in_collision_state with counter==SETTLE → CAPTURE; write pointer cleared.
  - Rising edge before settle completes is ignored; the sequencer waits for the next pass.
  - snap_req dropping to 0 → IDLE.
- CAPTURE:
  - Each cycle with collider_ready=1 and in_collision_state=1 and pointer<DEPTH: buf_we=1, buf_waddr=pointer (combinational, same cycle), pointer+1.
  - collider_ready=1 with pointer==DEPTH: no write; overflow set (sticky until next ARM→CAPTURE).
  - in_collision_state falls → HOLD next cycle; snap_count←pointer; snap_valid←1.
  - A sample coinciding with the falling edge is not written.
  - snap_req dropping in CAPTURE is ignored: the pass always completes.
- HOLD:
  - buf_we=0 guaranteed.
  - host_active=1: buf_re=1 and buf_raddr=host_cmd[ADDR_W-1:0], both registered (1-cycle latency).
  - Address ≥ snap_count: addr_err set (sticky until leaving HOLD); read still issued.
  - snap_req=0 and host_active=0 → IDLE next cycle; snap_valid, addr_err cleared.
  - snap_req=0 while host_active=1: remain in HOLD until host_active drops.
- host_active outside HOLD: buf_re stays 0; no error flag.
- busy=1 in ARM and CAPTURE only.
- Pointer width ADDR_W+1 so DEPTH=2^ADDR_W is representable; no wrap-around.

Optional Feature:
SNAP_FRAME_TAG_EN
- Defined:
  - A 16-bit pass counter increments on every falling edge of in_collision_state in any state, wrapping at 0xFFFF→0.
  - On ARM→CAPTURE, the current counter value is latched into snap_frame.
  - snap_frame holds until the next capture.
- Undefined: snap_frame tied to 0; counter logic absent.

Test Plan:
1. Reset mid-CAPTURE after 5 writes → all outputs 0 immediately, state IDLE; next capture starts at waddr 0.
2. snap_req=1, 6 idle cycles, pass with 8 collider_ready pulses, then in_collision_state↓ → buf_waddr 0..7 with buf_we, snap_count=8, snap_valid=1, busy=0.
3. Arm with in_collision_state low only 2 cycles before rising (SETTLE=4) → no writes that pass; next pass after ≥4 low cycles captures.
4. DEPTH=4, 6 samples in one pass → 4 writes (addr 0..3), overflow=1, snap_count=4.
5. HOLD with snap_count=8: host_cmd=0x8000_0003 → next cycle buf_re=1, buf_raddr=3; address 9 → addr_err=1; then host_cmd=0 → IDLE, snap_valid=0, addr_err=0.
6. SNAP_FRAME_TAG_EN: 3 passes elapse, then capture on the 4th → snap_frame=3; without the macro, snap_frame=0.
